// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Hazard and sequencing controller for the five-stage PPU pipeline
// (IF, ID, EX, MEM, WB). It produces the load enables, the NOP injection
// select, the IF/ID clear and the operand-forwarding selects. It also
// records its last action in a small state register guarded by a freeze
// watchdog.
//
// Optional feature macro: HAZARD_STATS_EN
//   defined   -> saturating STALL / FLUSH / FREEZE cycle counters are built
//   undefined -> the counter ports are tied to zero and no counter flops exist
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [4:0]       ex_rd,
    input  logic [4:0]       mem_rd,
    input  logic [4:0]       wb_rd,
    input  logic             ex_rf_en,
    input  logic             mem_rf_en,
    input  logic             wb_rf_en,
    input  logic             ex_load,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_ld,
    output logic             npc_ld,
    output logic             ifid_ld,
    output logic             idex_ld,
    output logic             pipe_ld,
    output logic             ifid_clr,
    output logic             cu_mux_s,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       state,
    output logic             hang_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] freeze_cycles
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_STALL  = 2'b01,
        ST_FLUSH  = 2'b10,
        ST_FREEZE = 2'b11
    } state_t;

    // Wide enough to hold TIMEOUT itself, since the freeze count saturates there.
    localparam int FRZ_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [FRZ_W-1:0] FRZ_MAX = FRZ_W'(TIMEOUT);

    state_t           state_q, state_d;
    state_t           action;
    logic [FRZ_W-1:0] frz_cnt_q, frz_cnt_d;
    logic             hang_err_q, hang_err_d;
    logic             lu_raw;
    logic             lu;
    logic [1:0]       fwd_a_raw;
    logic [1:0]       fwd_b_raw;

    // Saturating increment of the freeze watchdog count.
    function automatic logic [FRZ_W-1:0] frz_sat_inc(input logic [FRZ_W-1:0] v);
        if (v == FRZ_MAX) begin
            return v;
        end
        return v + FRZ_W'(1);
    endfunction

    // Forwarding source for one operand: the youngest producer wins, a load
    // still in EX has no data yet, and register 0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       use_src,
        input logic [4:0] e_rd,
        input logic       e_en,
        input logic       e_load,
        input logic [4:0] m_rd,
        input logic       m_en,
        input logic [4:0] w_rd,
        input logic       w_en
    );
        if (!use_src || src == 5'd0) begin
            return 2'b00;
        end
        if (e_en && e_rd == src && !e_load) begin
            return 2'b01;
        end
        if (m_en && m_rd == src) begin
            return 2'b10;
        end
        if (w_en && w_rd == src) begin
            return 2'b11;
        end
        return 2'b00;
    endfunction

    // Hazard detection and action selection for the current cycle.
    always_comb begin
        lu_raw = 1'b0;
        lu     = 1'b0;
        action = ST_RUN;
        if (ex_load && ex_rf_en && ex_rd != 5'd0) begin
            lu_raw = (id_use_rs && ex_rd == id_rs) || (id_use_rt && ex_rd == id_rt);
        end
        // After a STALL the bubble is already in EX, so a second bubble is never needed.
        lu = lu_raw && (state_q != ST_STALL);
        if (mem_busy) begin
            action = ST_FREEZE;
        end else if (lu) begin
            action = ST_STALL;
        end else if (branch_taken) begin
            action = ST_FLUSH;
        end else begin
            action = ST_RUN;
        end
    end

    // Operand-forwarding selects, independent of the chosen action.
    always_comb begin
        fwd_a_raw = fwd_sel(id_rs, id_use_rs, ex_rd, ex_rf_en, ex_load,
                            mem_rd, mem_rf_en, wb_rd, wb_rf_en);
        fwd_b_raw = fwd_sel(id_rt, id_use_rt, ex_rd, ex_rf_en, ex_load,
                            mem_rd, mem_rf_en, wb_rd, wb_rf_en);
    end

    // Pipeline control outputs; reset forces NOPs to flow through every stage.
    always_comb begin
        pc_ld    = 1'b1;
        npc_ld   = 1'b1;
        ifid_ld  = 1'b1;
        idex_ld  = 1'b1;
        pipe_ld  = 1'b1;
        ifid_clr = 1'b0;
        cu_mux_s = 1'b0;
        fwd_a    = fwd_a_raw;
        fwd_b    = fwd_b_raw;
        if (reset) begin
            ifid_clr = 1'b1;
            cu_mux_s = 1'b1;
            fwd_a    = 2'b00;
            fwd_b    = 2'b00;
        end else begin
            case (action)
                ST_STALL: begin
                    pc_ld    = 1'b0;
                    npc_ld   = 1'b0;
                    ifid_ld  = 1'b0;
                    cu_mux_s = 1'b1;
                end
                ST_FLUSH: begin
                    ifid_clr = 1'b1;
                end
                ST_FREEZE: begin
                    pc_ld   = 1'b0;
                    npc_ld  = 1'b0;
                    ifid_ld = 1'b0;
                    idex_ld = 1'b0;
                    pipe_ld = 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // Next state, watchdog count and sticky hang flag.
    always_comb begin
        state_d    = action;
        frz_cnt_d  = '0;
        hang_err_d = hang_err_q;
        if (action == ST_FREEZE) begin
            frz_cnt_d = frz_sat_inc(frz_cnt_q);
        end
        if (frz_cnt_d == FRZ_MAX) begin
            hang_err_d = 1'b1;
        end
    end

    // State, watchdog and hang registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            frz_cnt_q  <= '0;
            hang_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            frz_cnt_q  <= frz_cnt_d;
            hang_err_q <= hang_err_d;
        end
    end

    assign state    = state_q;
    assign hang_err = hang_err_q;

`ifdef HAZARD_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;
    logic [CNT_W-1:0] freeze_cycles_q, freeze_cycles_d;

    // Saturating increment of a statistics counter.
    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    // Count one event per cycle of the matching action.
    always_comb begin
        stall_cycles_d  = stall_cycles_q;
        flush_count_d   = flush_count_q;
        freeze_cycles_d = freeze_cycles_q;
        case (action)
            ST_STALL:  stall_cycles_d  = cnt_sat_inc(stall_cycles_q);
            ST_FLUSH:  flush_count_d   = cnt_sat_inc(flush_count_q);
            ST_FREEZE: freeze_cycles_d = cnt_sat_inc(freeze_cycles_q);
            default: begin
            end
        endcase
    end

    // Statistics counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q  <= '0;
            flush_count_q   <= '0;
            freeze_cycles_q <= '0;
        end else begin
            stall_cycles_q  <= stall_cycles_d;
            flush_count_q   <= flush_count_d;
            freeze_cycles_q <= freeze_cycles_d;
        end
    end

    assign stall_cycles  = stall_cycles_q;
    assign flush_count   = flush_count_q;
    assign freeze_cycles = freeze_cycles_q;
`else
    assign stall_cycles  = '0;
    assign flush_count   = '0;
    assign freeze_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: directed scenarios followed by random
// traffic, every cycle compared against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 16;
`ifdef HAZARD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk;
    logic reset;
    logic [4:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
    logic id_use_rs, id_use_rt, ex_rf_en, mem_rf_en, wb_rf_en;
    logic ex_load, branch_taken, mem_busy;
    logic pc_ld, npc_ld, ifid_ld, idex_ld, pipe_ld, ifid_clr, cu_mux_s;
    logic [1:0] fwd_a, fwd_b, state;
    logic hang_err;
    logic [CNT_W-1:0] stall_cycles, flush_count, freeze_cycles;

    pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_rf_en(ex_rf_en), .mem_rf_en(mem_rf_en), .wb_rf_en(wb_rf_en),
        .ex_load(ex_load), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_ld(pc_ld), .npc_ld(npc_ld), .ifid_ld(ifid_ld), .idex_ld(idex_ld),
        .pipe_ld(pipe_ld), .ifid_clr(ifid_clr), .cu_mux_s(cu_mux_s),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state), .hang_err(hang_err),
        .stall_cycles(stall_cycles), .flush_count(flush_count),
        .freeze_cycles(freeze_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: last action (0 RUN, 1 STALL, 2 FLUSH, 3 FREEZE) and registers.
    bit m_known = 1'b0;
    int m_state, m_frz, m_hang, m_stall, m_flush, m_freeze;
    int e_act;
    localparam int CNT_TOP = (1 << CNT_W) - 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] m_fwd(input logic [4:0] src, input logic use_src);
        logic [4:0] rd [3];
        logic       ok [3];
        rd = '{ex_rd, mem_rd, wb_rd};
        ok = '{ex_rf_en && !ex_load, mem_rf_en, wb_rf_en};
        if (!use_src || src == 5'd0) return 2'b00;
        for (int k = 0; k < 3; k++) begin
            if (ok[k] && rd[k] == src) return 2'(k + 1);
        end
        return 2'b00;
    endfunction

    // Settle combinational outputs, then compare everything against the model.
    task automatic eval(input string tag);
        bit lu;
        bit ld_front, ld_back;
        #1;
        lu = ex_load && ex_rf_en && ex_rd != 0 &&
             ((id_use_rs && ex_rd == id_rs) || (id_use_rt && ex_rd == id_rt)) &&
             !(m_known && m_state == 1);
        if (mem_busy)          e_act = 3;
        else if (lu)           e_act = 1;
        else if (branch_taken) e_act = 2;
        else                   e_act = 0;
        if (reset) begin
            chk({tag, ".pc_ld"},    32'(pc_ld),    1);
            chk({tag, ".npc_ld"},   32'(npc_ld),   1);
            chk({tag, ".ifid_ld"},  32'(ifid_ld),  1);
            chk({tag, ".idex_ld"},  32'(idex_ld),  1);
            chk({tag, ".pipe_ld"},  32'(pipe_ld),  1);
            chk({tag, ".ifid_clr"}, 32'(ifid_clr), 1);
            chk({tag, ".cu_mux_s"}, 32'(cu_mux_s), 1);
            chk({tag, ".fwd_a"},    32'(fwd_a),    0);
            chk({tag, ".fwd_b"},    32'(fwd_b),    0);
        end else begin
            ld_front = (e_act == 0 || e_act == 2);
            ld_back  = (e_act != 3);
            chk({tag, ".pc_ld"},    32'(pc_ld),    32'(ld_front));
            chk({tag, ".npc_ld"},   32'(npc_ld),   32'(ld_front));
            chk({tag, ".ifid_ld"},  32'(ifid_ld),  32'(ld_front));
            chk({tag, ".idex_ld"},  32'(idex_ld),  32'(ld_back));
            chk({tag, ".pipe_ld"},  32'(pipe_ld),  32'(ld_back));
            chk({tag, ".ifid_clr"}, 32'(ifid_clr), 32'(e_act == 2));
            chk({tag, ".cu_mux_s"}, 32'(cu_mux_s), 32'(e_act == 1));
            chk({tag, ".fwd_a"},    32'(fwd_a),    32'(m_fwd(id_rs, id_use_rs)));
            chk({tag, ".fwd_b"},    32'(fwd_b),    32'(m_fwd(id_rt, id_use_rt)));
        end
        if (m_known) begin
            chk({tag, ".state"},    32'(state),    32'(m_state));
            chk({tag, ".hang_err"}, 32'(hang_err), 32'(m_hang));
            chk({tag, ".stall_cycles"},  32'(stall_cycles),  STATS ? 32'(m_stall)  : 0);
            chk({tag, ".flush_count"},   32'(flush_count),   STATS ? 32'(m_flush)  : 0);
            chk({tag, ".freeze_cycles"}, 32'(freeze_cycles), STATS ? 32'(m_freeze) : 0);
        end
    endtask

    // Advance one clock edge and apply the same edge to the model.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_known = 1'b1;
            m_state = 0; m_frz = 0; m_hang = 0;
            m_stall = 0; m_flush = 0; m_freeze = 0;
        end else if (m_known) begin
            m_state = e_act;
            m_frz = (e_act == 3) ? ((m_frz < TIMEOUT) ? m_frz + 1 : TIMEOUT) : 0;
            if (m_frz == TIMEOUT) m_hang = 1;
            if (e_act == 1 && m_stall  < CNT_TOP) m_stall++;
            if (e_act == 2 && m_flush  < CNT_TOP) m_flush++;
            if (e_act == 3 && m_freeze < CNT_TOP) m_freeze++;
        end
        #1;
    endtask

    task automatic cycle(input string tag);
        eval(tag);
        tick();
    endtask

    task automatic idle_inputs();
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        ex_rd = 0; mem_rd = 0; wb_rd = 0;
        ex_rf_en = 0; mem_rf_en = 0; wb_rf_en = 0;
        ex_load = 0; branch_taken = 0; mem_busy = 0;
    endtask

    int burst;

    initial begin
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        // Reset held with mem_busy: NOPs flow regardless.
        mem_busy = 1;
        cycle("rst0");
        cycle("rst1");
        reset = 0; mem_busy = 0;
        cycle("run0");

        // Load-use: one bubble, then MEM forwarding.
        ex_load = 1; ex_rf_en = 1; ex_rd = 5; id_rs = 5; id_use_rs = 1;
        eval("lu");
        chk("lu.pc_ld_const", 32'(pc_ld), 0);
        chk("lu.cu_mux_const", 32'(cu_mux_s), 1);
        tick();
        ex_load = 0; ex_rf_en = 0; ex_rd = 0; mem_rd = 5; mem_rf_en = 1;
        eval("lu_next");
        chk("lu_next.state_const", 32'(state), 1);
        chk("lu_next.fwd_a_const", 32'(fwd_a), 2);
        chk("lu_next.pc_ld_const", 32'(pc_ld), 1);
        tick();

        // Forwarding priority on operand b.
        idle_inputs();
        ex_rd = 7; mem_rd = 7; wb_rd = 7; ex_rf_en = 1; mem_rf_en = 1; wb_rf_en = 1;
        id_rt = 7; id_use_rt = 1;
        eval("fwd_ex");  chk("fwd_ex.const", 32'(fwd_b), 1); tick();
        ex_rf_en = 0;
        eval("fwd_mem"); chk("fwd_mem.const", 32'(fwd_b), 2); tick();
        mem_rf_en = 0;
        eval("fwd_wb");  chk("fwd_wb.const", 32'(fwd_b), 3); tick();
        ex_rf_en = 1; mem_rf_en = 1; ex_rd = 0; mem_rd = 0; wb_rd = 0; id_rt = 0;
        eval("fwd_r0");  chk("fwd_r0.const", 32'(fwd_b), 0); tick();

        // Taken branch flushes; combined with load-use it stalls instead.
        idle_inputs();
        branch_taken = 1;
        eval("br"); chk("br.clr_const", 32'(ifid_clr), 1); tick();
        branch_taken = 0;
        eval("br_after"); chk("br_after.state_const", 32'(state), 2); tick();
        branch_taken = 1; ex_load = 1; ex_rf_en = 1; ex_rd = 9; id_rt = 9; id_use_rt = 1;
        eval("br_lu"); chk("br_lu.clr_const", 32'(ifid_clr), 0); tick();
        idle_inputs();
        cycle("br_lu_after");

        // Freeze for three cycles with a pending load-use, then stall once, then run.
        ex_load = 1; ex_rf_en = 1; ex_rd = 3; id_rs = 3; id_use_rs = 1; mem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            eval($sformatf("frz%0d", i));
            chk($sformatf("frz%0d.idex_const", i), 32'(idex_ld), 0);
            tick();
        end
        mem_busy = 0;
        eval("frz_stall"); chk("frz_stall.cu_const", 32'(cu_mux_s), 1); tick();
        eval("frz_run");   chk("frz_run.pc_const", 32'(pc_ld), 1); tick();
        idle_inputs();

        // Watchdog: six freeze cycles, sticky error until reset.
        mem_busy = 1;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) chk("wd.before_timeout", 32'(hang_err), 0);
            cycle($sformatf("wd%0d", i));
        end
        chk("wd.after_timeout", 32'(hang_err), 1);
        mem_busy = 0;
        cycle("wd_drop0");
        cycle("wd_drop1");
        chk("wd.sticky", 32'(hang_err), 1);

        // Reset in the middle of a freeze.
        mem_busy = 1;
        cycle("mid_frz");
        reset = 1;
        eval("rst_frz"); chk("rst_frz.cu_const", 32'(cu_mux_s), 1); tick();
        reset = 0;
        chk("rst_frz.state_const", 32'(state), 0);
        chk("rst_frz.hang_const", 32'(hang_err), 0);
        mem_busy = 0;
        cycle("rst_frz_run");

        // Random traffic with small register numbers to force collisions.
        burst = 0;
        for (int n = 0; n < 3000; n++) begin
            id_rs = 5'($urandom_range(0, 7));
            id_rt = 5'($urandom_range(0, 7));
            ex_rd = 5'($urandom_range(0, 7));
            mem_rd = 5'($urandom_range(0, 7));
            wb_rd = 5'($urandom_range(0, 7));
            id_use_rs = 1'($urandom_range(0, 1));
            id_use_rt = 1'($urandom_range(0, 1));
            ex_rf_en = 1'($urandom_range(0, 1));
            mem_rf_en = 1'($urandom_range(0, 1));
            wb_rf_en = 1'($urandom_range(0, 1));
            ex_load = ($urandom_range(0, 2) == 0);
            branch_taken = ($urandom_range(0, 3) == 0);
            if (burst > 0) begin
                mem_busy = 1; burst--;
            end else if ($urandom_range(0, 40) == 0) begin
                burst = $urandom_range(2, 7); mem_busy = 1;
            end else begin
                mem_busy = ($urandom_range(0, 7) == 0);
            end
            reset = ($urandom_range(0, 60) == 0);
            cycle("rnd");
        end
        reset = 0;
        idle_inputs();
        cycle("end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
